// File: rtl/score_counter_pkg.sv
// Shared types and display constants for the score counter and its display scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package score_counter_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;

  // Nibbles outside 0-9 are shown blank rather than as hex letters.
  function automatic logic [6:0] seg_pattern(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/score_counter_seg_scan.sv
// Multiplexed 4-digit display driver: rotates the active anode every SCAN_DIV
// cycles, showing ones on digit 0, tens on digit 1 and blanking digits 2/3.
module seg_scan
  import score_counter_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  bcd_t       tens,
  input  bcd_t       ones,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          wrap;

  // an/seg are derived from the next index so both change on the same edge.
  always_comb begin
    wrap   = (scan_q == CW'(SCAN_DIV - 1));
    scan_d = wrap ? '0 : scan_q + CW'(1);
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    an_d   = AN_D0;
    seg_d  = SEG_BLANK;
    case (idx_d)
      2'd0: begin an_d = AN_D0; seg_d = seg_pattern(ones); end
      2'd1: begin an_d = AN_D1; seg_d = seg_pattern(tens); end
      2'd2: begin an_d = AN_D2; seg_d = SEG_BLANK;         end
      default: begin an_d = AN_D3; seg_d = SEG_BLANK;      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= 2'd0;
      an_q   <= AN_D0;
      seg_q  <= SEG_0;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: rtl/score_counter.sv
// Button-event consumer: edge detect with lockout, saturating two-digit BCD
// score, and a multiplexed 7-segment display of the score.
module score_counter
  import score_counter_pkg::*;
#(
  parameter int MAX_COUNT   = 99,
  parameter int LOCKOUT_CYC = 16,
  parameter int SCAN_DIV    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up,
  input  logic       down,
  input  logic       reset,
  output logic [7:0] count,
  output logic       sat,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int   LW       = $clog2(LOCKOUT_CYC + 1);
  localparam bcd_t MAX_TENS = bcd_t'(MAX_COUNT / 10);
  localparam bcd_t MAX_ONES = bcd_t'(MAX_COUNT % 10);

  logic          up_prev_q, down_prev_q;
  logic          sat_q, sat_d;
  bcd_t          tens_q, tens_d, ones_q, ones_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          up_evt, down_evt, at_max, at_zero;

  always_comb begin
    up_evt   = up & ~up_prev_q;
    down_evt = down & ~down_prev_q;
    at_max   = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    at_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);
    tens_d   = tens_q;
    ones_d   = ones_q;
    sat_d    = 1'b0;
    lock_d   = (lock_q != '0) ? lock_q - LW'(1) : '0;
    if (reset) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
      lock_d = '0;
    end else if ((lock_q == '0) && (up_evt ^ down_evt)) begin
      // Saturated events still start the lockout so a held-off press can't retrigger.
      lock_d = LW'(LOCKOUT_CYC);
      if (up_evt) begin
        if (at_max) begin
          sat_d = 1'b1;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (at_zero) begin
          sat_d = 1'b1;
        end else if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
      sat_q       <= 1'b0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      lock_q      <= '0;
    end else begin
      up_prev_q   <= up;
      down_prev_q <= down;
      sat_q       <= sat_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      lock_q      <= lock_d;
    end
  end

  assign count = {tens_q, ones_q};
  assign sat   = sat_q;

  seg_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_seg_scan (
    .clk  (clk),
    .rst_n(rst_n),
    .tens (tens_q),
    .ones (ones_q),
    .an   (an),
    .seg  (seg)
  );

endmodule

// File: tb/tb_score_counter.sv
// Directed and randomized bench for score_counter against an integer score model.
module tb_score_counter;

  localparam int MAXC = 99;
  localparam int LOCK = 16;
  localparam int SDIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] count;
  logic       sat;
  logic [3:0] an;
  logic [6:0] seg;

  always #5 clk = ~clk;

  score_counter #(
    .MAX_COUNT  (MAXC),
    .LOCKOUT_CYC(LOCK),
    .SCAN_DIV   (SDIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .up   (up),
    .down (down),
    .reset(reset),
    .count(count),
    .sat  (sat),
    .an   (an),
    .seg  (seg)
  );

  int passed = 0;
  int total  = 0;

  // Reference model state: score as a plain integer, lockout as cycles remaining.
  int   m_score, m_lock, m_edges, m_disp;
  bit   m_up_p, m_dn_p, m_sat;
  logic [6:0] seg_tab [10];

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_score = 0; m_lock = 0; m_edges = 0; m_disp = 0;
    m_up_p = 0; m_dn_p = 0; m_sat = 0;
  endtask

  task automatic model_edge(input bit u, input bit d, input bit r);
    bit ue, de;
    m_disp  = m_score;
    m_edges++;
    ue = u && !m_up_p;
    de = d && !m_dn_p;
    m_up_p = u;
    m_dn_p = d;
    m_sat  = 0;
    if (r) begin
      m_score = 0;
      m_lock  = 0;
    end else if (m_lock == 0 && ue != de) begin
      m_lock = LOCK;
      if (ue) begin
        if (m_score == MAXC) m_sat = 1; else m_score++;
      end else begin
        if (m_score == 0) m_sat = 1; else m_score--;
      end
    end else if (m_lock > 0) begin
      m_lock--;
    end
  endtask

  task automatic check_all(input string tag);
    int idx;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    idx = (m_edges / SDIV) % 4;
    case (idx)
      0: begin e_an = 4'b1110; e_seg = seg_tab[m_disp % 10]; end
      1: begin e_an = 4'b1101; e_seg = seg_tab[m_disp / 10]; end
      2: begin e_an = 4'b1011; e_seg = 7'b1111111; end
      default: begin e_an = 4'b0111; e_seg = 7'b1111111; end
    endcase
    chk({tag, ".count"}, count, to_bcd(m_score));
    chk({tag, ".sat"}, {7'b0, sat}, {7'b0, m_sat});
    chk({tag, ".an"}, {4'b0, an}, {4'b0, e_an});
    chk({tag, ".seg"}, {1'b0, seg}, {1'b0, e_seg});
  endtask

  task automatic step(input bit u, input bit d, input bit r, input string tag);
    up = u; down = d; reset = r;
    @(posedge clk);
    model_edge(u, d, r);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, "idle");
  endtask

  task automatic press(input bit is_up);
    step(is_up, !is_up, 0, "press");
    idle(LOCK + 1);
  endtask

  task automatic goto_score(input int target);
    while (m_score < target) press(1);
    while (m_score > target) press(0);
  endtask

  initial begin
    int base;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    model_reset();

    // Power-on reset state
    rst_n = 1'b0;
    #12;
    check_all("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: three spaced up pulses
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, "t1_up");
      chk("t1_nosat", {7'b0, sat}, 8'h00);
      idle(19);
    end
    chk("t1_count3", count, 8'h03);

    // 2: long hold counts once; a second pulse inside lockout is ignored
    base = m_score;
    for (int i = 0; i < 100; i++) step(1, 0, 0, "t2_hold");
    step(0, 0, 0, "t2_rel");
    chk("t2_hold_once", count, to_bcd(base + 1));
    idle(LOCK + 1);
    base = m_score;
    step(1, 0, 0, "t2_p1");
    idle(4);
    step(1, 0, 0, "t2_p2");
    idle(LOCK + 1);
    chk("t2_lockout", count, to_bcd(base + 1));

    // 3: BCD carry/borrow and saturation at both ends
    goto_score(9);
    press(1);
    chk("t3_carry", count, 8'h10);
    press(0);
    chk("t3_borrow", count, 8'h09);
    goto_score(0);
    step(0, 1, 0, "t3_dn0");
    chk("t3_floor_sat", {7'b0, sat}, 8'h01);
    chk("t3_floor_cnt", count, 8'h00);
    step(0, 0, 0, "t3_dn0b");
    chk("t3_floor_sat_end", {7'b0, sat}, 8'h00);
    idle(LOCK);
    goto_score(99);
    step(1, 0, 0, "t3_up99");
    chk("t3_ceil_sat", {7'b0, sat}, 8'h01);
    chk("t3_ceil_cnt", count, 8'h99);
    idle(LOCK + 1);

    // 4: simultaneous edges do nothing and do not start lockout
    goto_score(5);
    step(1, 1, 0, "t4_both");
    chk("t4_both_cnt", count, 8'h05);
    step(0, 1, 0, "t4_upfall");
    step(1, 1, 0, "t4_upnew");
    chk("t4_noblock", count, 8'h06);
    idle(LOCK + 1);

    // 5: game reset with up held through it
    goto_score(42);
    step(1, 0, 0, "t5_pre");
    idle(LOCK + 1);
    goto_score(42);
    for (int i = 0; i < 3; i++) step(1, 0, 1, "t5_rst");
    for (int i = 0; i < 5; i++) step(1, 0, 0, "t5_held");
    chk("t5_held_zero", count, 8'h00);
    step(0, 0, 0, "t5_fall");
    step(1, 0, 0, "t5_rise");
    chk("t5_after", count, 8'h01);
    idle(LOCK + 1);

    // 6: display scan at 37, then async reset mid-scan
    goto_score(37);
    idle(18);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_an_rst", {4'b0, an}, 8'h0E);
    check_all("t6_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    idle(9);

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      bit ru, rd, rr;
      ru = ($urandom_range(0, 99) < 40);
      rd = ($urandom_range(0, 99) < 30);
      rr = ($urandom_range(0, 79) == 0);
      step(ru, rd, rr, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/score_counter.md
Name: score_counter

Overview:
Consumer side of the player button interface. Takes the registered up/down/reset levels, converts each up/down press into a single event with a lockout window, and keeps a saturating two-digit BCD score. It also drives the board's multiplexed 4-digit active-low 7-segment display. It sits between the button input stage and the board display pins.

Parameters:
MAX_COUNT, 99, upper saturation value of the score; legal range 1..99.
LOCKOUT_CYC, 16, number of clk cycles after an accepted event during which further up/down edges are ignored.
SCAN_DIV, 1024, clk cycles each display digit is held before the anode rotates; must be >= 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
up  in  1  registered level from the button stage, count-up request
down  in  1  registered level from the button stage, count-down request
reset  in  1  registered level from the button stage, game clear; synchronous
count  out  8  score as packed BCD {tens[3:0], ones[3:0]}
sat  out  1  one-cycle pulse when an accepted event hits a limit and is discarded
an  out  4  digit anodes, active-low; an[0] is the rightmost digit
seg  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (rst_n=0, async): count=8'h00, sat=0, lockout counter=0, up_prev=down_prev=0, scan counter=0, an=4'b1110, seg=7'b1000000 (digit "0").
- Edge detect: up_evt = up & ~up_prev; down_evt = down & ~down_prev. The prev registers update every cycle, including during lockout and game reset.
- Accept condition: an event is accepted only when reset=0 and the lockout counter is 0.
- Accepted up_evt alone:
  - count < MAX_COUNT: BCD increment (ones 9 wraps to 0 with carry into tens). The new count is visible on the cycle after the edge is sampled (1-cycle latency).
  - count == MAX_COUNT: count is unchanged and sat pulses for 1 cycle.
- Accepted down_evt alone: BCD decrement (ones 0 becomes 9 with borrow), with the same latency. At 00 the count is unchanged and sat pulses.
- up_evt and down_evt in the same cycle: no count change, no sat, lockout is not started.
- Any accepted single event, including a saturated one, loads the lockout counter with LOCKOUT_CYC. The counter decrements once per cycle down to 0.
- Game reset, while reset=1:
  - count=00 on the next edge, lockout counter forced to 0, up/down ignored.
  - The first edge after reset drops is accepted, but only if its prev register was 0 during the reset cycle, i.e. a button held through reset does not count.
- Display scan: a scan counter counts 0..SCAN_DIV-1. At wrap, the digit index advances 0→1→2→3→0.
  - index 0: an=1110, seg shows ones.
  - index 1: an=1101, seg shows tens.
  - index 2 and 3: an=1011 / 0111, seg=7'b1111111 (blank).
- an and seg are registered and update together, with no cycle where two anodes are low.
- Digit patterns: standard active-low hex for 0-9. Any other nibble displays as blank.
- rst_n asserted mid-lockout or mid-scan returns everything to the reset values immediately.

Decomposition:
- Shared package:
  - BCD digit typedef (4-bit).
  - Ten 7-segment constants SEG_0..SEG_9, plus SEG_BLANK.
  - Anode one-cold constants AN_D0..AN_D3.
- One sub-module: seg_scan. It holds the scan counter, digit index, and registered an/seg, takes {tens, ones}, and uses the package patterns. score_counter holds edge detect, lockout and BCD arithmetic.

Test Plan:
1. rst_n low, then high; pulse up high for 1 cycle, 3 times, spaced 20 cycles apart -> count=8'h03, sat never asserted.
2. up held high for 100 cycles, then low -> count advances by exactly 1. Two up pulses 5 cycles apart (inside LOCKOUT_CYC=16) -> only the first counts.
3. Preload to 8'h09, then one up -> 8'h10. One down -> 8'h09. From 00, down -> stays 00 and sat=1 for one cycle. Count to 99 plus one more up -> stays 99 with a sat pulse.
4. up and down rising on the same cycle at count 8'h05 -> count stays 05. A new up edge the next cycle is accepted (no lockout) -> 8'h06.
5. count=8'h42, reset high 3 cycles with up held high throughout, then reset low with up still high -> count=00 and stays 00. After up falls and rises again -> 01.
6. SCAN_DIV=4, count=8'h37 -> an cycles 1110/1101/1011/0111 every 4 cycles with seg = SEG_7, SEG_3, blank, blank. rst_n pulse mid-scan -> an=1110 immediately.
